ntt_butterfly_sequencer: RTL and testbench

Address and twiddle sequencer for the iterative radix-2 Cooley-Tukey NTT. On `start` it walks every stage and butterfly of an N-point transform (N = 2^LOG_N). For each butterfly it emits the two coefficient-memory addresses and the twiddle index through a valid/ready handshake. These values drive the operand and weight fetch that feeds the modular multiply stage. A programmable inter-stage bubble lets the write-back of stage s drain before stage s+1 reads.

---
 rtl/ntt_butterfly_sequencer_if.sv | 38 +++
 rtl/ntt_butterfly_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_ntt_butterfly_sequencer.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ntt_butterfly_sequencer_if.sv
// Butterfly output bus: operand addresses, twiddle index and stage markers,
// carried with a valid/ready handshake from the sequencer to the fetch stage.
interface ntt_butterfly_sequencer_if #(
    parameter int LOG_N = 8
);
    localparam int SW = $clog2(LOG_N);

    logic             out_valid;
    logic             out_ready;
    logic [LOG_N-1:0] addr_a;
    logic [LOG_N-1:0] addr_b;
    logic [LOG_N-2:0] tw_idx;
    logic [SW-1:0]    stage;
    logic             stage_last;
    logic             final_flag;

    modport master (
        output out_valid,
        output addr_a,
        output addr_b,
        output tw_idx,
        output stage,
        output stage_last,
        output final_flag,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  addr_a,
        input  addr_b,
        input  tw_idx,
        input  stage,
        input  stage_last,
        input  final_flag,
        output out_ready
    );
endinterface

// File: rtl/ntt_butterfly_sequencer.sv
// Address and twiddle sequencer for an iterative radix-2 Cooley-Tukey NTT.
// Walks every stage and butterfly of a 2^LOG_N point transform and presents
// one butterfly per handshake, with an optional idle gap between stages.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; payload cleared
// RUN   | presenting butterfly (stage, b); advances on each transfer
// GAP   | inter-stage bubble of STAGE_GAP cycles, out_valid low
// DONE  | one-cycle done pulse, then back to IDLE
module ntt_butterfly_sequencer #(
    parameter int LOG_N     = 8,
    parameter int STAGE_GAP = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic abort,
    output logic busy,
    output logic done,
    ntt_butterfly_sequencer_if.master bus
);
    localparam int SW = $clog2(LOG_N);
    localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;

    localparam logic [LOG_N-2:0] B_LAST     = '1;
    localparam logic [SW-1:0]    STAGE_LAST = SW'(LOG_N - 1);
    // Gap timer is a down-counter loaded with STAGE_GAP-1 and left at zero.
    localparam logic [GW-1:0]    GAP_LOAD   = GW'((STAGE_GAP > 0) ? (STAGE_GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [LOG_N-2:0] b_q, b_d;
    logic [SW-1:0]    stage_q, stage_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic             xfer;

    logic [LOG_N-1:0] b_ext;
    logic [LOG_N-1:0] half;
    logic [LOG_N-1:0] lo_mask;
    logic [LOG_N-1:0] j_val;
    logic [LOG_N-1:0] grp;
    logic [LOG_N-1:0] addr_a_d;
    logic [LOG_N-1:0] addr_b_d;
    logic [LOG_N-2:0] tw_d;
    logic             stage_last_d;
    logic             final_d;
    logic             active_d;

    logic [LOG_N-1:0] addr_a_q;
    logic [LOG_N-1:0] addr_b_q;
    logic [LOG_N-2:0] tw_q;
    logic [SW-1:0]    stage_out_q;
    logic             stage_last_q;
    logic             final_q;

    // out_valid is a pure state decode, so a transfer is valid-in-RUN and ready.
    assign xfer = (state_q == S_RUN) && bus.out_ready;

    // State, butterfly counter, stage counter and gap timer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            stage_q <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            stage_q <= stage_d;
            gap_q   <= gap_d;
        end
    end

    // Next-state and counter update; abort overrides everything else.
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        stage_d = stage_q;
        gap_d   = gap_q;
        if (abort) begin
            state_d = S_IDLE;
            b_d     = '0;
            stage_d = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RUN;
                        b_d     = '0;
                        stage_d = '0;
                    end
                end
                S_RUN: begin
                    if (xfer) begin
                        if (b_q != B_LAST) begin
                            b_d = b_q + 1'b1;
                        end else if (stage_q != STAGE_LAST) begin
                            b_d     = '0;
                            stage_d = stage_q + 1'b1;
                            if (STAGE_GAP == 0) begin
                                state_d = S_RUN;
                            end else begin
                                state_d = S_GAP;
                                gap_d   = GAP_LOAD;
                            end
                        end else begin
                            state_d = S_DONE;
                            b_d     = '0;
                            stage_d = '0;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_q == '0) begin
                        state_d = S_RUN;
                    end else begin
                        gap_d = gap_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Butterfly payload for the next (b, stage); only changes when b/stage do.
    always_comb begin
        b_ext        = {1'b0, b_d};
        half         = LOG_N'(1) << stage_d;
        lo_mask      = half - LOG_N'(1);
        j_val        = b_ext & lo_mask;
        grp          = b_ext >> stage_d;
        addr_a_d     = ((grp << stage_d) << 1) + j_val;
        addr_b_d     = addr_a_d + half;
        // j < half <= N/2, so it fits the twiddle width before the shift.
        tw_d         = j_val[LOG_N-2:0] << (STAGE_LAST - stage_d);
        stage_last_d = (b_d == B_LAST);
        final_d      = stage_last_d && (stage_d == STAGE_LAST);
        active_d     = (state_d == S_RUN) || (state_d == S_GAP);
    end

    // Registered payload, cleared whenever the sequencer is not mid-transform.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            tw_q         <= '0;
            stage_out_q  <= '0;
            stage_last_q <= 1'b0;
            final_q      <= 1'b0;
        end else if (active_d) begin
            addr_a_q     <= addr_a_d;
            addr_b_q     <= addr_b_d;
            tw_q         <= tw_d;
            stage_out_q  <= stage_d;
            stage_last_q <= stage_last_d;
            final_q      <= final_d;
        end else begin
            addr_a_q     <= '0;
            addr_b_q     <= '0;
            tw_q         <= '0;
            stage_out_q  <= '0;
            stage_last_q <= 1'b0;
            final_q      <= 1'b0;
        end
    end

    assign bus.out_valid  = (state_q == S_RUN);
    assign bus.addr_a     = addr_a_q;
    assign bus.addr_b     = addr_b_q;
    assign bus.tw_idx     = tw_q;
    assign bus.stage      = stage_out_q;
    assign bus.stage_last = stage_last_q;
    assign bus.final_flag = final_q;
    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_DONE);
endmodule

// File: tb/tb_ntt_butterfly_sequencer.sv
// Bench for ntt_butterfly_sequencer: an 8-point instance with a 4-cycle
// stage gap and a 4-point instance with no gap, checked each cycle against a
// transaction-level model, plus hand-computed sequences and cycle numbers.
module tb_ntt_butterfly_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    logic start_a, abort_a, busy_a, done_a;
    logic start_b, abort_b, busy_b, done_b;

    ntt_butterfly_sequencer_if #(.LOG_N(3)) bus_a ();
    ntt_butterfly_sequencer_if #(.LOG_N(2)) bus_b ();

    ntt_butterfly_sequencer #(.LOG_N(3), .STAGE_GAP(4)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .bus(bus_a.master)
    );

    ntt_butterfly_sequencer #(.LOG_N(2), .STAGE_GAP(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .bus(bus_b.master)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int a; int b; int tw; int sg; int sl; int fn; int rel;
    } xfer_t;

    xfer_t log_a[$];
    xfer_t log_b[$];

    int n_tests = 0;
    int n_fail  = 0;

    int lg[2] = '{3, 2};
    int gp[2] = '{4, 0};
    int m_busy[2]   = '{0, 0};
    int m_valid[2]  = '{0, 0};
    int m_done[2]   = '{0, 0};
    int m_idx[2]    = '{0, 0};
    int m_gap[2]    = '{0, 0};
    int t0[2]       = '{0, 0};
    int stalls[2]   = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int done_rel[2] = '{0, 0};
    int done_cyc[2] = '{0, 0};
    int vh[32];

    localparam int EXP_AA[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    localparam int EXP_AB[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    localparam int EXP_TW[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic chk(input string nm, input int d, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0d, expected %0d (t=%0t)", nm, d, act, exp, $time);
        end
    endtask

    // Butterfly idx of the whole transform, straight from the stage/group/offset rules.
    function automatic void exp_item(input int d, input int idx, output int a, output int b,
                                     output int tw, output int s, output int sl, output int fn);
        int h, bb, half, j, g;
        h    = (1 << lg[d]) / 2;
        s    = idx / h;
        bb   = idx % h;
        half = 1 << s;
        j    = bb % half;
        g    = bb / half;
        a    = g * 2 * half + j;
        b    = a + half;
        tw   = j * (1 << (lg[d] - 1 - s));
        sl   = (bb == h - 1) ? 1 : 0;
        fn   = (sl == 1 && s == lg[d] - 1) ? 1 : 0;
    endfunction

    // Compare one DUT against the model for this cycle, then advance the model
    // with the inputs the coming edge will sample.
    task automatic mon(input int d, input logic v, input int aa, input int ab, input int tw,
                       input int sg, input logic sl, input logic fn, input logic bsy,
                       input logic dn, input logic st, input logic abt, input logic rdy);
        int ea, eb, et, es, esl, efn, total, rel;
        xfer_t e;
        total = lg[d] * (1 << lg[d]) / 2;
        if (!rst_n) begin
            m_busy[d] = 0; m_valid[d] = 0; m_done[d] = 0; m_gap[d] = 0; m_idx[d] = 0;
        end
        chk("out_valid", d, int'(v), m_valid[d]);
        chk("busy", d, int'(bsy), m_busy[d]);
        chk("done", d, int'(dn), m_done[d]);
        esl = 0;
        if (m_valid[d] != 0) begin
            exp_item(d, m_idx[d], ea, eb, et, es, esl, efn);
            chk("addr_a", d, aa, ea);
            chk("addr_b", d, ab, eb);
            chk("tw_idx", d, tw, et);
            chk("stage", d, sg, es);
            chk("stage_last", d, int'(sl), esl);
            chk("final", d, int'(fn), efn);
        end
        rel = cyc - t0[d];
        if (d == 0 && rel >= 0 && rel < 32) vh[rel] = int'(v);
        if (rst_n && !abt && v && rdy) begin
            e.a = aa; e.b = ab; e.tw = tw; e.sg = sg; e.sl = int'(sl); e.fn = int'(fn); e.rel = rel;
            if (d == 0) log_a.push_back(e);
            else        log_b.push_back(e);
        end
        if (dn) begin
            done_cnt[d]++;
            done_rel[d] = rel;
            done_cyc[d] = cyc;
        end
        if (!rst_n) begin
        end else if (abt) begin
            m_busy[d] = 0; m_valid[d] = 0; m_done[d] = 0; m_gap[d] = 0; m_idx[d] = 0;
        end else if (m_done[d] != 0) begin
            m_done[d] = 0;
            m_busy[d] = 0;
        end else if (m_busy[d] == 0) begin
            if (st) begin
                m_busy[d] = 1; m_valid[d] = 1; m_idx[d] = 0; t0[d] = cyc; stalls[d] = 0;
            end
        end else if (m_valid[d] != 0) begin
            if (rdy) begin
                if (m_idx[d] == total - 1) begin
                    m_valid[d] = 0;
                    m_done[d]  = 1;
                end else begin
                    if (esl == 1 && gp[d] > 0) begin
                        m_valid[d] = 0;
                        m_gap[d]   = gp[d];
                    end
                    m_idx[d]++;
                end
            end else begin
                stalls[d]++;
            end
        end else begin
            m_gap[d]--;
            if (m_gap[d] == 0) m_valid[d] = 1;
        end
    endtask

    // Single compare process for both instances, away from the active edge.
    always @(negedge clk) begin
        mon(0, bus_a.out_valid, int'(bus_a.addr_a), int'(bus_a.addr_b), int'(bus_a.tw_idx),
            int'(bus_a.stage), bus_a.stage_last, bus_a.final_flag, busy_a, done_a,
            start_a, abort_a, bus_a.out_ready);
        mon(1, bus_b.out_valid, int'(bus_b.addr_a), int'(bus_b.addr_b), int'(bus_b.tw_idx),
            int'(bus_b.stage), bus_b.stage_last, bus_b.final_flag, busy_b, done_b,
            start_b, abort_b, bus_b.out_ready);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input int d, input int target, input int max_ticks);
        int k;
        k = 0;
        while (done_cnt[d] < target && k < max_ticks) begin
            tick();
            k++;
        end
        chk("done_reached", d, done_cnt[d], target);
    endtask

    task automatic zero_a(input string nm);
        chk({nm, "_valid"}, 0, int'(bus_a.out_valid), 0);
        chk({nm, "_addr_a"}, 0, int'(bus_a.addr_a), 0);
        chk({nm, "_addr_b"}, 0, int'(bus_a.addr_b), 0);
        chk({nm, "_tw"}, 0, int'(bus_a.tw_idx), 0);
        chk({nm, "_stage"}, 0, int'(bus_a.stage), 0);
        chk({nm, "_stage_last"}, 0, int'(bus_a.stage_last), 0);
        chk({nm, "_final"}, 0, int'(bus_a.final_flag), 0);
        chk({nm, "_busy"}, 0, int'(busy_a), 0);
        chk({nm, "_done"}, 0, int'(done_a), 0);
    endtask

    task automatic check_seq_a(input string nm);
        chk({nm, "_len"}, 0, log_a.size(), 12);
        for (int i = 0; i < 12 && i < log_a.size(); i++) begin
            chk({nm, "_a"}, 0, log_a[i].a, EXP_AA[i]);
            chk({nm, "_b"}, 0, log_a[i].b, EXP_AB[i]);
            chk({nm, "_tw"}, 0, log_a[i].tw, EXP_TW[i]);
            chk({nm, "_sl"}, 0, log_a[i].sl, (i % 4 == 3) ? 1 : 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int c1;
        int t;
        logic [15:0] pat;
        rst_n = 1'b0;
        start_a = 1'b0; abort_a = 1'b0;
        start_b = 1'b0; abort_b = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        zero_a("reset");
        chk("reset_valid", 1, int'(bus_b.out_valid), 0);
        chk("reset_busy", 1, int'(busy_b), 0);
        rst_n = 1'b1;
        tick();

        // Full run on both instances, out_ready held high.
        start_a = 1'b1; start_b = 1'b1;
        tick();
        start_a = 1'b0; start_b = 1'b0;
        wait_done(0, 1, 60);
        wait_done(1, 1, 60);
        check_seq_a("run");
        chk("run_done_cycle", 0, done_rel[0], 21);
        for (int r = 1; r <= 20; r++)
            chk("run_valid_hist", 0, vh[r], ((r >= 5 && r <= 8) || (r >= 13 && r <= 16)) ? 0 : 1);
        chk("n4_len", 1, log_b.size(), 4);
        if (log_b.size() == 4) begin
            chk("n4_a0", 1, log_b[0].a, 0);  chk("n4_b0", 1, log_b[0].b, 1);
            chk("n4_a1", 1, log_b[1].a, 2);  chk("n4_b1", 1, log_b[1].b, 3);
            chk("n4_a2", 1, log_b[2].a, 0);  chk("n4_b2", 1, log_b[2].b, 2);
            chk("n4_a3", 1, log_b[3].a, 1);  chk("n4_b3", 1, log_b[3].b, 3);
            chk("n4_tw3", 1, log_b[3].tw, 1);
            chk("n4_sl", 1, log_b[0].sl * 8 + log_b[1].sl * 4 + log_b[2].sl * 2 + log_b[3].sl, 5);
            chk("n4_final", 1, log_b[0].fn * 8 + log_b[1].fn * 4 + log_b[2].fn * 2 + log_b[3].fn, 1);
            chk("n4_rel_last", 1, log_b[3].rel, 4);
        end
        chk("n4_done_cycle", 1, done_rel[1], 5);
        log_a.delete();
        log_b.delete();
        tick();

        // Stalls from a fixed ready pattern, with start pulses mid-run.
        t = done_cnt[0];
        pat = 16'hB6E5;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (done_cnt[0] < t + 1 && k < 200) begin
            bus_a.out_ready = pat[k % 16];
            start_a = (k == 5 || k == 12) ? 1'b1 : 1'b0;
            tick();
            k++;
        end
        start_a = 1'b0;
        bus_a.out_ready = 1'b1;
        chk("stall_done_reached", 0, done_cnt[0], t + 1);
        check_seq_a("stall");
        chk("stall_done_cycle", 0, done_rel[0], 21 + stalls[0]);
        log_a.delete();
        tick();

        // Abort while stage 1, b=2 is presented.
        t = done_cnt[0];
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (!(bus_a.out_valid && bus_a.stage == 2'd1 && bus_a.addr_a == 3'd4) && k < 40) begin
            tick();
            k++;
        end
        chk("abort_reach_rel", 0, cyc - t0[0], 11);
        abort_a = 1'b1;
        tick();
        abort_a = 1'b0;
        chk("abort_valid", 0, int'(bus_a.out_valid), 0);
        chk("abort_busy", 0, int'(busy_a), 0);
        chk("abort_done", 0, int'(done_a), 0);
        repeat (5) tick();
        chk("abort_no_done", 0, done_cnt[0], t);
        chk("abort_xfers", 0, log_a.size(), 6);
        log_a.delete();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done(0, t + 1, 60);
        check_seq_a("restart");
        chk("restart_done_cycle", 0, done_rel[0], 21);
        log_a.delete();
        tick();

        // Asynchronous reset in the middle of the first gap.
        t = done_cnt[0];
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        k = 0;
        while (!(busy_a && !bus_a.out_valid) && k < 40) begin
            tick();
            k++;
        end
        chk("gap_reach_rel", 0, cyc - t0[0], 5);
        #2;
        rst_n = 1'b0;
        #1;
        zero_a("async_rst");
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        log_a.delete();
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        wait_done(0, t + 1, 60);
        check_seq_a("post_rst");
        chk("post_rst_done_cycle", 0, done_rel[0], 21);
        log_a.delete();
        tick();

        // start held high: the transform repeats back to back.
        t = done_cnt[0];
        start_a = 1'b1;
        wait_done(0, t + 1, 80);
        c1 = done_cyc[0];
        wait_done(0, t + 2, 80);
        start_a = 1'b0;
        chk("held_period", 0, done_cyc[0] - c1, 22);
        chk("held_done_cycle", 0, done_rel[0], 21);
        repeat (3) tick();
        chk("held_idle_busy", 0, int'(busy_a), 0);
        chk("held_no_third", 0, done_cnt[0], t + 2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
